// File: rtl/dcache_wr_buf_if.sv
// Bus bundle between the D-cache, the write buffer and the AXI write engine.
// slave = buffer side, master = environment driving the buffer.
interface dcache_wr_buf_if #(
    parameter int D_LINE_WIDTH = 128
);
    logic                    in_req;
    logic                    in_rdy;
    logic                    in_burst;
    logic [D_LINE_WIDTH-1:0] in_data;
    logic [31:0]             in_addr;
    logic [1:0]              in_size;
    logic [3:0]              in_strb;
    logic                    wr_req;
    logic                    wr_rdy;
    logic                    burst;
    logic [D_LINE_WIDTH-1:0] data;
    logic [31:0]             addr;
    logic [1:0]              size;
    logic [3:0]              strb;
    logic                    wr_idle;
    logic [31:0]             rd_addr;
    logic                    rd_hit;
    logic                    all_idle;

    modport slave (
        input  in_req, in_burst, in_data, in_addr, in_size, in_strb,
        input  wr_rdy, wr_idle, rd_addr,
        output in_rdy, wr_req, burst, data, addr, size, strb, rd_hit, all_idle
    );

    modport master (
        output in_req, in_burst, in_data, in_addr, in_size, in_strb,
        output wr_rdy, wr_idle, rd_addr,
        input  in_rdy, wr_req, burst, data, addr, size, strb, rd_hit, all_idle
    );
endinterface

// File: rtl/dcache_wr_buf.sv
// In-order write buffer between D-cache and axi_wr with line-address hazard check.
// Optional store merging into the tail entry is enabled by defining WR_BUF_MERGE_EN.
module dcache_wr_buf #(
    parameter int D_BYTES_PER_LINE = 16,
    parameter int D_LINE_WIDTH     = D_BYTES_PER_LINE * 8,
    parameter int DEPTH            = 4,
    parameter int PTR_WIDTH        = $clog2(DEPTH),
    parameter int OFS_WIDTH        = $clog2(D_BYTES_PER_LINE)
) (
    input  logic             clk,
    input  logic             resetn,
    dcache_wr_buf_if.slave   bus
);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1'b1);
    localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH+1)'(1'b1);
    localparam logic [PTR_WIDTH:0]   COUNT_FULL = (PTR_WIDTH+1)'(DEPTH);

    logic [PTR_WIDTH-1:0]    rptr_q, rptr_d;
    logic [PTR_WIDTH-1:0]    wptr_q, wptr_d;
    logic [PTR_WIDTH:0]      count_q, count_d;
    logic                    rdy_en_q;

    logic                    burst_q [DEPTH];
    logic [31:0]             addr_q  [DEPTH];
    logic [1:0]              size_q  [DEPTH];
    logic [3:0]              strb_q  [DEPTH];
    logic [D_LINE_WIDTH-1:0] data_q  [DEPTH];

    logic                    pop_s;
    logic                    mergeable_s;
    logic                    in_rdy_s;
    logic                    push_s;
    logic                    alloc_s;
    logic                    merge_do_s;
    logic                    hit_s;
    logic [PTR_WIDTH-1:0]    hit_idx_s;

    // Handshake decode: pop whenever axi_wr is ready and something is queued.
    always_comb begin
        pop_s      = (count_q != '0) & bus.wr_rdy;
        in_rdy_s   = rdy_en_q & ((count_q != COUNT_FULL) | mergeable_s);
        push_s     = bus.in_req & in_rdy_s;
        alloc_s    = push_s & ~mergeable_s;
        merge_do_s = push_s & mergeable_s;
    end

`ifdef WR_BUF_MERGE_EN
    logic [PTR_WIDTH-1:0] tail_ptr_s;

    // A word store to the same word as a non-departing single-store tail folds into it.
    always_comb begin
        tail_ptr_s  = wptr_q - PTR_ONE;
        mergeable_s = 1'b0;
        if ((count_q != '0) && !bus.in_burst && (bus.in_size == 2'b10) &&
            !burst_q[tail_ptr_s] && (size_q[tail_ptr_s] == 2'b10) &&
            (addr_q[tail_ptr_s][31:2] == bus.in_addr[31:2]) &&
            ((count_q > CNT_ONE) || !pop_s)) begin
            mergeable_s = 1'b1;
        end else begin
            mergeable_s = 1'b0;
        end
    end
`else
    assign mergeable_s = 1'b0;
`endif

    // Pointer and occupancy next-state.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        if (alloc_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (alloc_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!alloc_s && pop_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Control state; in_rdy stays low until the first clock after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Entry storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            burst_q[wptr_q] <= bus.in_burst;
            addr_q[wptr_q]  <= bus.in_addr;
            size_q[wptr_q]  <= bus.in_size;
            strb_q[wptr_q]  <= bus.in_strb;
            data_q[wptr_q]  <= bus.in_data;
        end
`ifdef WR_BUF_MERGE_EN
        else if (merge_do_s) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.in_strb[i]) begin
                    data_q[tail_ptr_s][8*i +: 8] <= bus.in_data[8*i +: 8];
                end
            end
            strb_q[tail_ptr_s] <= strb_q[tail_ptr_s] | bus.in_strb;
        end
`endif
    end

    // Hazard: any valid entry (including one leaving now) or the incoming one on the same line.
    always_comb begin
        hit_s     = push_s & (bus.in_addr[31:OFS_WIDTH] == bus.rd_addr[31:OFS_WIDTH]);
        hit_idx_s = rptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            hit_idx_s = rptr_q + PTR_WIDTH'(k);
            hit_s     = hit_s | (((PTR_WIDTH+1)'(k) < count_q) &&
                        (addr_q[hit_idx_s][31:OFS_WIDTH] == bus.rd_addr[31:OFS_WIDTH]));
        end
    end

    assign bus.in_rdy   = in_rdy_s;
    assign bus.wr_req   = pop_s;
    assign bus.burst    = burst_q[rptr_q];
    assign bus.addr     = addr_q[rptr_q];
    assign bus.size     = size_q[rptr_q];
    assign bus.strb     = strb_q[rptr_q];
    assign bus.data     = data_q[rptr_q];
    assign bus.rd_hit   = hit_s;
    assign bus.all_idle = (count_q == '0) & bus.wr_idle;
endmodule
